// File: rtl/sys_clken_pkg.sv
// Shared types and defaults for the multi-channel clock-enable generator.
package sys_clken_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StLocking,
        StRun,
        StSettle
    } clken_state_e;

    localparam int unsigned LockCyclesDefault   = 1024;
    localparam int unsigned SettleCyclesDefault = 64;

    // Channel-select width; at least one bit even for a single channel.
    function automatic int unsigned ch_w(input int unsigned num_ch);
        int unsigned w;
        w = (num_ch > 1) ? $clog2(num_ch) : 1;
        return w;
    endfunction

endpackage

// File: rtl/clken_phase_acc.sv
// One channel of the enable generator: increment register, phase accumulator
// and the registered strobe taken from the accumulator carry.
module clken_phase_acc #(
    parameter int unsigned     AccW    = 32,
    parameter logic [AccW-1:0] InitInc = '0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            clear_i,
    input  logic            load_i,
    input  logic [AccW-1:0] inc_i,
    input  logic            run_i,
    input  logic            gate_i,
    output logic            ce_o
);

    logic [AccW-1:0] inc_q, inc_d;
    logic [AccW-1:0] acc_q, acc_d;
    logic            ce_q, ce_d;
    logic [AccW:0]   sum;

    // Next increment and phase; the carry out of the add is the only strobe source.
    always_comb begin
        sum   = {1'b0, acc_q} + {1'b0, inc_q};
        inc_d = load_i ? inc_i : inc_q;
        acc_d = acc_q;
        if (clear_i || !run_i) begin
            acc_d = '0;
        end else begin
            acc_d = sum[AccW-1:0];
        end
        ce_d = gate_i && sum[AccW];
    end

    // Channel state registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            inc_q <= InitInc;
            acc_q <= '0;
            ce_q  <= 1'b0;
        end else begin
            inc_q <= inc_d;
            acc_q <= acc_d;
            ce_q  <= ce_d;
        end
    end

    assign ce_o = ce_q;

endmodule

// File: rtl/sys_clken_gen.sv
// Multi-channel fractional clock-enable generator with lock/settle sequencing.
// Optional build macro CLKEN_PHASE_RESYNC_EN: any accepted valid reconfig clears
// every channel's accumulator so all channels restart phase-aligned.
module sys_clken_gen
    import sys_clken_pkg::*;
#(
    parameter int unsigned              NUM_CH        = 3,
    parameter int unsigned              ACC_W         = 32,
    parameter int unsigned              LOCK_CYCLES   = LockCyclesDefault,
    parameter int unsigned              SETTLE_CYCLES = SettleCyclesDefault,
    parameter logic [NUM_CH*ACC_W-1:0]  INIT_INC      = '0
) (
    input  logic                    refclk,
    input  logic                    rst,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    input  logic [ch_w(NUM_CH)-1:0] cfg_ch,
    input  logic [ACC_W-1:0]        cfg_inc,
    output logic                    cfg_err,
    output logic [NUM_CH-1:0]       ce,
    output logic                    locked
);

    localparam int unsigned CH_W    = ch_w(NUM_CH);
    localparam int unsigned LockW   = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam int unsigned SettleW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [LockW-1:0]   LockLast   = LockW'(LOCK_CYCLES - 1);
    localparam logic [SettleW-1:0] SettleLast = SettleW'(SETTLE_CYCLES - 1);
    localparam logic [CH_W:0]      NumChLim   = (CH_W + 1)'(NUM_CH);

    clken_state_e       state_q, state_d;
    logic [LockW-1:0]   lock_cnt_q, lock_cnt_d;
    logic [SettleW-1:0] settle_cnt_q, settle_cnt_d;
    logic               cfg_err_q, cfg_err_d;

    logic cfg_fire;   // handshake completed this cycle
    logic ch_ok;      // addressed channel exists
    logic cfg_ok;     // completed handshake that actually reconfigures
    logic run_acc;    // accumulators advance
    logic gate;       // strobes may be registered this cycle
    logic clear_all;

    assign cfg_ready = (state_q == StLocking) || (state_q == StRun);
    assign locked    = (state_q == StRun);
    assign cfg_err   = cfg_err_q;

    assign cfg_fire = cfg_valid && cfg_ready;
    assign ch_ok    = ({1'b0, cfg_ch} < NumChLim);
    assign cfg_ok   = cfg_fire && ch_ok;
    assign run_acc  = (state_q == StRun) || (state_q == StSettle);
    // A reconfig in RUN moves to SETTLE next cycle, so its strobes are dropped too.
    assign gate     = (state_q == StRun) && !cfg_ok;

`ifdef CLKEN_PHASE_RESYNC_EN
    assign clear_all = cfg_ok;
`else
    assign clear_all = 1'b0;
`endif

    // Lock/settle sequencing and reconfig decode.
    always_comb begin
        state_d      = state_q;
        lock_cnt_d   = lock_cnt_q;
        settle_cnt_d = settle_cnt_q;
        cfg_err_d    = cfg_fire && !ch_ok;
        unique case (state_q)
            StIdle: begin
                lock_cnt_d = '0;
                state_d    = StLocking;
            end
            StLocking: begin
                if (cfg_ok) begin
                    // A reconfig restarts the lock interval, even on its last cycle.
                    lock_cnt_d = '0;
                end else if (lock_cnt_q == LockLast) begin
                    lock_cnt_d = '0;
                    state_d    = StRun;
                end else begin
                    lock_cnt_d = lock_cnt_q + 1'b1;
                end
            end
            StRun: begin
                if (cfg_ok) begin
                    settle_cnt_d = '0;
                    state_d      = StSettle;
                end
            end
            StSettle: begin
                if (settle_cnt_q == SettleLast) begin
                    settle_cnt_d = '0;
                    state_d      = StRun;
                end else begin
                    settle_cnt_d = settle_cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Control registers with synchronous reset.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q      <= StIdle;
            lock_cnt_q   <= '0;
            settle_cnt_q <= '0;
            cfg_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            lock_cnt_q   <= lock_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            cfg_err_q    <= cfg_err_d;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic hit;
        assign hit = cfg_ok && (cfg_ch == CH_W'(i));

        clken_phase_acc #(
            .AccW    (ACC_W),
            .InitInc (INIT_INC[i*ACC_W +: ACC_W])
        ) u_acc (
            .clk_i   (refclk),
            .rst_i   (rst),
            .clear_i (hit || clear_all),
            .load_i  (hit),
            .inc_i   (cfg_inc),
            .run_i   (run_acc),
            .gate_i  (gate),
            .ce_o    (ce[i])
        );
    end

endmodule

// File: tb/tb_sys_clken_gen.sv
// Scoreboard bench for sys_clken_gen: stimulus pushes expected strobe cycles,
// level changes and error pulses; a negedge monitor pops and compares them.
module tb_sys_clken_gen;

    localparam int NCH = 3;
    localparam int W   = 3070;  // RUN reconfig of ch2
    localparam int W2  = 3100;  // reconfig of ch1, reset arrives mid-SETTLE

    typedef struct packed {
        int         cyc;
        logic [1:0] lv;   // {locked, cfg_ready}
    } lev_t;

    logic           refclk = 1'b0;
    logic           rst = 1'b1;
    logic           cfg_valid = 1'b0;
    logic           cfg_ready;
    logic [1:0]     cfg_ch = '0;
    logic [31:0]    cfg_inc = '0;
    logic           cfg_err;
    logic [NCH-1:0] ce;
    logic           locked;

    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   cnt1 = 0;
    bit   mon_en = 1'b1;
    int   q_ce [NCH][$];
    int   q_err[$];
    lev_t q_lev[$];
    logic [1:0] lev_prev = 2'b00;

    sys_clken_gen #(
        .NUM_CH        (NCH),
        .ACC_W         (32),
        .LOCK_CYCLES   (16),
        .SETTLE_CYCLES (8),
        .INIT_INC      ('0)
    ) dut (
        .refclk    (refclk),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_inc   (cfg_inc),
        .cfg_err   (cfg_err),
        .ce        (ce),
        .locked    (locked)
    );

    always #5 refclk = ~refclk;

    always @(posedge refclk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge refclk);
            #1;
        end
    endtask

    task automatic tick_to(input int target);
        while (cyc < target) tick(1);
    endtask

    // Expected strobes of a channel whose phase was zero after edge org.
    task automatic push_ce(input int ch, input int org, input int per, input int lo,
                           input int hi);
        for (int c = org + per; c <= hi; c += per) begin
            if (c >= lo) q_ce[ch].push_back(c);
        end
    endtask

    task automatic push_lev(input int c, input logic [1:0] lv);
        lev_t e;
        e.cyc = c;
        e.lv  = lv;
        q_lev.push_back(e);
    endtask

    // Holds a request until it is accepted; returns the accepting edge, or -1.
    task automatic cfg_xfer(input logic [1:0] ch, input logic [31:0] inc, output int acc_n);
        logic rdy;
        acc_n     = -1;
        cfg_valid = 1'b1;
        cfg_ch    = ch;
        cfg_inc   = inc;
        for (int i = 0; i < 64; i++) begin
            rdy = cfg_ready;
            tick(1);
            if (rdy) begin
                acc_n = cyc;
                break;
            end
        end
    endtask

    // Monitor: compares every strobe, level change and error pulse with the queues.
    always @(negedge refclk) begin : monitor
        int   nxt;
        lev_t e;
        logic [1:0] lv;
        if (mon_en && cyc > 0) begin
            for (int ch = 0; ch < NCH; ch++) begin
                while (q_ce[ch].size() > 0 && q_ce[ch][0] < cyc) begin
                    nxt = q_ce[ch].pop_front();
                    n_tests++;
                    n_fail++;
                    $display("FAIL ce%0d_missed: no strobe seen, required one at cycle %0d",
                             ch, nxt);
                end
                if (ce[ch] !== 1'b0) begin
                    n_tests++;
                    nxt = (q_ce[ch].size() > 0) ? q_ce[ch][0] : -1;
                    if (ce[ch] === 1'b1 && nxt == cyc) begin
                        void'(q_ce[ch].pop_front());
                    end else begin
                        n_fail++;
                        $display("FAIL ce%0d_strobe: got ce=%b at cycle %0d, next required %0d",
                                 ch, ce[ch], cyc, nxt);
                    end
                    if (ch == 1 && cyc >= 61 && cyc <= 3060) cnt1++;
                end
            end
            if (cfg_err !== 1'b0) begin
                n_tests++;
                nxt = (q_err.size() > 0) ? q_err[0] : -1;
                if (cfg_err === 1'b1 && nxt == cyc) begin
                    void'(q_err.pop_front());
                end else begin
                    n_fail++;
                    $display("FAIL cfg_err_pulse: got %b at cycle %0d, next required %0d",
                             cfg_err, cyc, nxt);
                end
            end
            lv = {locked, cfg_ready};
            if (lv !== lev_prev) begin
                n_tests++;
                if (q_lev.size() == 0) begin
                    n_fail++;
                    $display("FAIL level_change: got {locked,ready}=%b at cycle %0d, none required",
                             lv, cyc);
                end else begin
                    e = q_lev.pop_front();
                    if (e.cyc != cyc || e.lv !== lv) begin
                        n_fail++;
                        $display("FAIL level_change: got %b at cycle %0d, required %b at %0d",
                                 lv, cyc, e.lv, e.cyc);
                    end
                end
                lev_prev = lv;
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int a;
        // Reset values
        tick(3);
        check("reset_outputs", {ce, locked, cfg_ready, cfg_err}, '0);

        // Lock timing with INIT_INC = 0: ready after edge 4, locked after edge 20
        push_lev(4, 2'b01);
        push_lev(20, 2'b11);
        rst = 1'b0;
        tick_to(25);

        // Reset from RUN, then reconfig in LOCKING and on the terminal lock cycle
        push_lev(26, 2'b00);
        push_lev(27, 2'b01);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(1);
        cfg_xfer(2'd0, 32'h4000_0000, a);
        check("lock_cfg_ch0_edge", a, 28);
        cfg_valid = 1'b0;
        tick_to(43);
        cfg_xfer(2'd1, 32'h5555_5556, a);
        check("lock_terminal_cfg_edge", a, 44);
        cfg_valid = 1'b0;
        push_lev(60, 2'b11);
        push_ce(0, 60, 4, 61, W - 1);
        push_ce(1, 60, 3, 61, W - 1);

        // Fractional rate over 3000 RUN cycles
        tick_to(3061);
        check("ch1_rate_1000", (cnt1 >= 999 && cnt1 <= 1001), 1);

        // Reconfig in RUN -> SETTLE, with a held invalid-channel request behind it
        tick_to(W - 1);
        cfg_xfer(2'd2, 32'h8000_0000, a);
        check("run_cfg_ch2_edge", a, W);
        push_lev(W, 2'b00);
        push_lev(W + 8, 2'b11);
        q_err.push_back(W + 9);
`ifdef CLKEN_PHASE_RESYNC_EN
        push_ce(0, W, 4, W + 9, W2 - 1);
        push_ce(1, W, 3, W + 9, W2 - 1);
`else
        push_ce(0, 60, 4, W + 9, W2 - 1);
        push_ce(1, 60, 3, W + 9, W2 - 1);
`endif
        push_ce(2, W, 2, W + 9, W2 - 1);
        cfg_xfer(2'd3, 32'hdead_beef, a);
        check("held_cfg_accept_edge", a, W + 9);
        cfg_valid = 1'b0;

        // Reset in the middle of SETTLE restores INIT_INC (no strobes afterwards)
        tick_to(W2 - 1);
        cfg_xfer(2'd1, 32'h8000_0000, a);
        check("settle_cfg_edge", a, W2);
        cfg_valid = 1'b0;
        push_lev(W2, 2'b00);
        push_lev(W2 + 4, 2'b01);
        push_lev(W2 + 20, 2'b11);
        tick_to(W2 + 2);
        rst = 1'b1;
        tick(1);
        check("rst_mid_settle_outputs", {ce, locked, cfg_ready, cfg_err}, '0);
        rst = 1'b0;
        tick_to(3140);

        // Integer-ratio channels written in LOCKING strobe together every 4 cycles
        push_lev(3141, 2'b00);
        push_lev(3142, 2'b01);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(1);
        cfg_xfer(2'd0, 32'h4000_0000, a);
        check("final_cfg_ch0_edge", a, 3143);
        cfg_xfer(2'd1, 32'h8000_0000, a);
        check("final_cfg_ch1_edge", a, 3144);
        cfg_valid = 1'b0;
        push_lev(3160, 2'b11);
        push_ce(0, 3160, 4, 3161, 3201);
        push_ce(1, 3160, 2, 3161, 3201);
        tick_to(3202);
        mon_en = 1'b0;

        check("ce0_queue_drained", q_ce[0].size(), 0);
        check("ce1_queue_drained", q_ce[1].size(), 0);
        check("ce2_queue_drained", q_ce[2].size(), 0);
        check("err_queue_drained", q_err.size(), 0);
        check("level_queue_drained", q_lev.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
